// File: rtl/fp_pkg.sv
// Constants shared by the fmul datapath and its result queue: exception flag
// bit positions, the canonical quiet NaN, and a precision-tagging helper.
package fp_pkg;

  localparam int FLG_NV  = 4;
  localparam int FLG_OF  = 3;
  localparam int FLG_UF  = 2;
  localparam int FLG_RSV = 1;
  localparam int FLG_NX  = 0;

  localparam int          RESULT_W = 32;
  localparam logic [31:0] QNAN32   = 32'h7FC0_0000;

  // Half-precision results occupy the low 16 bits; the upper half is forced
  // to zero so stale upstream bits never leak to the consumer.
  function automatic logic [RESULT_W-1:0] tag_result(
    input logic [RESULT_W-1:0] result,
    input logic                mode_fp
  );
    return mode_fp ? result : {16'h0000, result[15:0]};
  endfunction

endpackage

// File: rtl/fp_fifo_mem.sv
// Storage array for the result queue: DEPTH x W registers, synchronous write,
// asynchronous (combinational) read. No reset; occupancy is tracked outside.
module fp_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 38
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fp_result_queue.sv
// Show-ahead result queue behind the fmul unit with a precision tag per entry
// and sticky accumulation of exception flags for the consumer.
module fp_result_queue
  import fp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int FW    = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_result,
  input  logic [FW-1:0]            in_flags,
  input  logic                     in_mode_fp,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [FW-1:0]            out_flags,
  output logic                     out_mode_fp,
  output logic [FW-1:0]            fflags,
  input  logic                     fflags_clr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = RESULT_W + FW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high. in_ready and out_valid depend only on registered occupancy, so
  // a full queue refuses a push even when a pop happens in the same cycle.

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [FW-1:0] fflags_q;
  logic [FW-1:0] fflags_next;
  logic          push;
  logic          pop;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;

  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign wr_entry = {tag_result(in_result, in_mode_fp), in_flags, in_mode_fp};

  fp_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  // Flags pushed in the same cycle as a clear survive the clear.
  always_comb begin
    fflags_next = fflags_clr ? '0 : fflags_q;
    if (push) begin
      fflags_next = fflags_next | in_flags;
    end
    fflags_next[FLG_RSV] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      fflags_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      fflags_q <= fflags_next;
    end
  end

  // Head fields read as zero whenever the queue is empty, including in reset.
  always_comb begin
    out_result  = '0;
    out_flags   = '0;
    out_mode_fp = 1'b0;
    if (out_valid) begin
      out_result  = rd_entry[EW-1 -: RESULT_W];
      out_flags   = rd_entry[FW:1];
      out_mode_fp = rd_entry[0];
    end
  end

  assign fflags = fflags_q;
  assign count  = count_q;

endmodule
